// File: rtl/alu_reg_pkg.sv
// Shared defaults and FSM encoding for the ALU register sequencer.
package alu_reg_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_4x8.sv
// Register file: one synchronous write port, three combinational read ports
// (operand A, operand B, debug). Asynchronous active-high clear.
module regfile_4x8
  import alu_reg_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic [ADDR_W-1:0] raddr_d,
  output logic [WIDTH-1:0]  rdata_d
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];

  // Storage: cleared on reset, written on the rising edge when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: pure combinational lookups
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    rdata_d = regs[raddr_d];
  end

endmodule

// File: rtl/alu_reg_sequencer.sv
// Command sequencer around an external combinational ALU: loads immediates
// or stages two register operands on R2/R3 and writes the ALU result back.
module alu_reg_sequencer
  import alu_reg_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [WIDTH-1:0]  cmd_imm,
  output logic [WIDTH-1:0]  R2,
  output logic [WIDTH-1:0]  R3,
  input  logic [WIDTH-1:0]  alu_result,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  state_t              state;
  logic [ADDR_W-1:0]   dst;
  logic                accept;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [WIDTH-1:0]    wdata;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;

  assign accept = cmd_valid && cmd_ready;

  // Write-port steering: immediate on a load accept, ALU result at end of EXEC
  always_comb begin
    we    = 1'b0;
    waddr = cmd_dst;
    wdata = cmd_imm;
    if (state == S_IDLE && accept && cmd_load) begin
      we = 1'b1;
    end else if (state == S_EXEC) begin
      we    = 1'b1;
      waddr = dst;
      wdata = alu_result;
    end
  end

  regfile_4x8 #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (cmd_src_a),
    .rdata_a (op_a),
    .raddr_b (cmd_src_b),
    .rdata_b (op_b),
    .raddr_d (rd_addr),
    .rdata_d (rd_data)
  );

  // Sequencer FSM with registered ready/done/operand outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      R2        <= '0;
      R3        <= '0;
      dst       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            if (cmd_load) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_EXEC;
              R2    <= op_a;
              R3    <= op_b;
              dst   <= cmd_dst;
            end
          end
        end
        S_EXEC: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Directed bench for alu_reg_sequencer with a NAND ALU and a result scoreboard.
module tb_alu_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_src_a;
  logic [1:0] cmd_src_b;
  logic [7:0] cmd_imm;
  logic [7:0] R2;
  logic [7:0] R3;
  logic [7:0] alu_result;
  logic       done;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m [4];

  always #5 clk = ~clk;

  assign alu_result = ~(R2 & R3);

  alu_reg_sequencer #(
    .WIDTH  (8),
    .ADDR_W (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_load   (cmd_load),
    .cmd_dst    (cmd_dst),
    .cmd_src_a  (cmd_src_a),
    .cmd_src_b  (cmd_src_b),
    .cmd_imm    (cmd_imm),
    .R2         (R2),
    .R3         (R3),
    .alu_result (alu_result),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(tag, {24'h0, rd_data}, {24'h0, exp});
  endtask

  // Drive one command, wait for accept and done, check latency/operands/result.
  task automatic run_cmd(input string tag, input logic ld, input logic [1:0] d,
                         input logic [1:0] a, input logic [1:0] b, input logic [7:0] imm);
    logic [7:0] opa, opb, res;
    exp_t       e;
    int         cnt;
    int         lat;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = ld; cmd_dst = d;
    cmd_src_a = a; cmd_src_b = b; cmd_imm = imm;
    opa = m[a]; opb = m[b];
    res = ld ? imm : ~(opa & opb);
    e.addr = d; e.data = res;
    sb.push_back(e);
    m[d] = res;
    cnt = 0;
    while (!cmd_ready && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    if (!cmd_ready) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (!ld && lat == 1) begin
        check({tag, "_R2_exec"}, {24'h0, R2}, {24'h0, opa});
        check({tag, "_R3_exec"}, {24'h0, R3}, {24'h0, opb});
        check({tag, "_ready_exec"}, {31'h0, cmd_ready}, 32'd0);
      end
      if (done) break;
    end
    check({tag, "_latency"}, lat, ld ? 32'd1 : 32'd2);
    check({tag, "_ready_done"}, {31'h0, cmd_ready}, 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_reg({tag, "_result"}, e.addr, e.data);
    end
  endtask

  initial begin
    int acc;
    int dones;
    logic exp_ready [6];
    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_dst = '0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_imm = '0; rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("ready_after_reset", {31'h0, cmd_ready}, 32'd1);
    check("done_after_reset", {31'h0, done}, 32'd0);

    // Loads
    run_cmd("load_r1", 1'b1, 2'd1, 2'd0, 2'd0, 8'hF0);
    run_cmd("load_r2", 1'b1, 2'd2, 2'd0, 2'd0, 8'h3C);
    check_reg("r1_after_loads", 2'd1, 8'hF0);
    check_reg("r2_after_loads", 2'd2, 8'h3C);

    // ALU ops, including src == dst
    run_cmd("alu_r3", 1'b0, 2'd3, 2'd1, 2'd2, 8'h00);
    check_reg("r3_nand", 2'd3, 8'hCF);
    run_cmd("alu_r1_self", 1'b0, 2'd1, 2'd1, 2'd1, 8'h00);
    check_reg("r1_self", 2'd1, 8'h0F);

    // Held cmd_valid for 6 cycles: r3 <= ~(r3 & r3), one execution per IDLE visit
    exp_ready = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_dst = 2'd3;
    cmd_src_a = 2'd3; cmd_src_b = 2'd3;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("held_ready_%0d", i), {31'h0, cmd_ready}, {31'h0, exp_ready[i]});
      if (cmd_ready) acc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    m[3] = ~(m[3] & m[3]);
    m[3] = ~(m[3] & m[3]);
    check("held_accepts", acc, 32'd2);
    check_reg("held_r3", 2'd3, m[3]);

    // Reset during EXEC of an op targeting r2
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_dst = 2'd2;
    cmd_src_a = 2'd1; cmd_src_b = 2'd3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("exec_rst_ready", {31'h0, cmd_ready}, 32'd1);
    check("exec_rst_R2", {24'h0, R2}, 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("exec_rst_no_done", dones, 32'd0);
    check("exec_rst_idle", {31'h0, cmd_ready}, 32'd1);
    check_reg("exec_rst_r2", 2'd2, 8'h00);

    // Mid-cycle asynchronous reset during DONE with non-zero state
    run_cmd("load2_r1", 1'b1, 2'd1, 2'd0, 2'd0, 8'hA5);
    run_cmd("load2_r2", 1'b1, 2'd2, 2'd0, 2'd0, 8'h5A);
    run_cmd("alu_r0", 1'b0, 2'd0, 2'd1, 2'd2, 8'h00);
    rst = 1'b1;
    #1;
    check("async_rst_done", {31'h0, done}, 32'd0);
    check("async_rst_ready", {31'h0, cmd_ready}, 32'd1);
    check("async_rst_R2", {24'h0, R2}, 32'd0);
    check("async_rst_R3", {24'h0, R3}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_reg($sformatf("async_rst_rd%0d", i), 2'(i), 8'h00);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_reg_sequencer.md
ALU_REG_SEQUENCER -- requirements
Module: alu_reg_sequencer

Interface
REQ-001 Parameter: WIDTH, 8, data width of registers, operands and result.
REQ-002 Parameter: ADDR_W, 2, register address width (2**ADDR_W registers).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_load  input  1  1 = load cmd_imm into cmd_dst; 0 = ALU operation.
REQ-008 cmd_dst  input  ADDR_W  destination register.
REQ-009 cmd_src_a / cmd_src_b  input  ADDR_W each  source registers for the ALU operation.
REQ-010 cmd_imm  input  WIDTH  immediate value for load.
REQ-011 R2  output  WIDTH  operand A to the external combinational ALU.
REQ-012 R3  output  WIDTH  operand B to the external combinational ALU.
REQ-013 alu_result  input  WIDTH  ALU result, a combinational function of R2/R3.
REQ-014 done  output  1  one-cycle pulse when a command completes.
REQ-015 rd_addr  input  ADDR_W; rd_data  output  WIDTH  combinational debug read of the register file.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-017 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; no command is accepted otherwise.
REQ-018 Load accept: regs[cmd_dst] SHALL be written with cmd_imm at the accept edge; next state is DONE.
REQ-019 ALU accept: R2 <= regs[cmd_src_a], R3 <= regs[cmd_src_b], and dst is captured at the accept edge; next state is EXEC.
REQ-020 EXEC SHALL last exactly one cycle; at its ending edge regs[dst] <= alu_result, and the next state is DONE.
REQ-021 DONE SHALL last one cycle with done = 1; the next state is IDLE. done SHALL be 0 in every other state.
REQ-022 Latency from the accept edge to done high: load = 1 cycle, ALU = 2 cycles; throughput is at most one command per 2 cycles (load) or 3 cycles (ALU).
REQ-023 Operands SHALL be read at the accept edge, so src == dst uses the pre-write value.
REQ-024 R2/R3 SHALL hold their last values outside EXEC.
REQ-025 Result width SHALL be WIDTH; no carry or extension is stored.
REQ-026 rd_data SHALL reflect a register write from the cycle after the write edge.
REQ-027 cmd_valid asserted while busy SHALL be ignored until IDLE, and a held command SHALL execute exactly once per handshake.

Reset
REQ-028 When rst = 1, all registers, R2, R3, done and the captured dst SHALL be cleared to 0 and the state SHALL be IDLE immediately, without waiting for a clock edge.
REQ-029 A reset asserted in EXEC or DONE SHALL abort the command; no write occurs.
REQ-030 After release, cmd_ready SHALL be 1 and the first command is accepted at the first qualifying edge.

Structure
REQ-031 Package alu_reg_pkg SHALL hold WIDTH, ADDR_W defaults and the FSM state encoding.
REQ-032 Storage SHALL be one sub-module, regfile_4x8: one write port and three read ports (operand A, operand B, debug); the FSM stays in alu_reg_sequencer.
REQ-033 The ALU SHALL remain external; this block contains no arithmetic or logic on the data.

Verification (bench ALU = bitwise NAND of R2, R3)
REQ-034 Reset: assert rst mid-cycle -> all outputs 0 and cmd_ready = 1 before the next edge; rd_data = 0 for every address.
REQ-035 Load 0xF0 -> r1 and 0x3C -> r2 -> done 1 cycle after each accept; rd_data(r1) = 0xF0 and rd_data(r2) = 0x3C.
REQ-036 ALU op dst = r3, src = r1, r2 -> R2 = 0xF0 and R3 = 0x3C during EXEC; done 2 cycles after accept; r3 = 0xCF.
REQ-037 ALU op dst = r1, src = r1, r1 -> r1 = 0x0F, with the operand read before the write.
REQ-038 cmd_valid held high for 6 cycles with one ALU command -> exactly one accept per IDLE visit, and cmd_ready = 0 in EXEC and DONE.
REQ-039 rst pulsed during EXEC of an op with dst = r2 -> r2 = 0, no done pulse, and state returns to IDLE.
